folded_majority_eval: RTL and testbench

//  Sequential, folded counterpart to the combinational majority netlists: accepts one
//  N-bit vector over valid/ready, sums its ones FOLD bits per cycle in a shared adder,
//  and returns the majority decision (popcount >= THRESH) over a second valid/ready port.

---
 rtl/folded_majority_eval_if.sv | 26 ++
 rtl/folded_majority_eval.sv | 104 ++++++++++
 tb/tb_folded_majority_eval.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/folded_majority_eval_if.sv
// Handshake bundle for the folded majority evaluator: vector in, decision out.
// out_hw exists only when MAJ_HW_OUT_EN is defined.
interface folded_majority_eval_if #(
   parameter int N  = 37,
   parameter int CW = $clog2(N + 1)
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_x;
   logic          out_valid;
   logic          out_ready;
   logic          out_y;
`ifdef MAJ_HW_OUT_EN
   logic [CW-1:0] out_hw;

   modport master (output in_valid, in_x, out_ready,
                   input  in_ready, out_valid, out_y, out_hw);
   modport slave  (input  in_valid, in_x, out_ready,
                   output in_ready, out_valid, out_y, out_hw);
`else
   modport master (output in_valid, in_x, out_ready,
                   input  in_ready, out_valid, out_y);
   modport slave  (input  in_valid, in_x, out_ready,
                   output in_ready, out_valid, out_y);
`endif
endinterface

// File: rtl/folded_majority_eval.sv
// Folded majority evaluator: sums FOLD bits of a captured vector per cycle and
// reports popcount >= THRESH. Define MAJ_HW_OUT_EN to expose the ones count on out_hw.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// ACCUM | summing one chunk per cycle, fixed NCHUNK cycles
// DONE  | result valid, held until out_ready
module folded_majority_eval #(
   parameter int N      = 37,
   parameter int FOLD   = 8,
   parameter int THRESH = (N + 1) / 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   folded_majority_eval_if.slave bus
);
   localparam int NCHUNK = (N + FOLD - 1) / FOLD;
   localparam int CW     = $clog2(N + 1);
   localparam int PW     = NCHUNK * FOLD;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [31:0] THRESH_U = 32'(THRESH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]      state;
   logic [PW-1:0]   vec;
   logic [CW-1:0]   acc;
   logic [IW-1:0]   idx;
   logic            out_valid;
   logic            out_y;
   logic [FOLD-1:0] chunk;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   acc_next;
   logic            last;
`ifdef MAJ_HW_OUT_EN
   logic [CW-1:0]   hw_q;
   assign bus.out_hw = hw_q;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid;
   assign bus.out_y     = out_y;
   assign last          = (idx == IW'(NCHUNK - 1));

   // vec is zero-extended on capture, so padding bits of the last chunk add nothing
   always_comb begin
      chunk = '0;
      for (int c = 0; c < NCHUNK; c++) begin
         if (idx == IW'(c)) chunk = vec[c*FOLD +: FOLD];
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < FOLD; i++) cnt = cnt + CW'(chunk[i]);
      acc_next = acc + cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec       <= '0;
         acc       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_y     <= 1'b0;
`ifdef MAJ_HW_OUT_EN
         hw_q      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  vec   <= PW'(bus.in_x);
                  acc   <= '0;
                  idx   <= '0;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (last) begin
                  out_y     <= (32'(acc_next) >= THRESH_U);
`ifdef MAJ_HW_OUT_EN
                  hw_q      <= acc_next;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_folded_majority_eval.sv
// Directed and randomized bench for folded_majority_eval at N=37, FOLD=8, THRESH=19.
// Reference result is popcount(x) >= 19 with an in-order queue of accepted vectors.
module tb_folded_majority_eval;
   localparam int N = 37;
   localparam int THR = 19;
   localparam int NRAND = 4000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   folded_majority_eval_if #(.N(N)) intf ();
   folded_majority_eval #(.N(N), .FOLD(8), .THRESH(THR)) dut (
      .clk(clk), .rst_n(rst_n), .bus(intf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_hw(input string tag, input int exp);
`ifdef MAJ_HW_OUT_EN
      check(tag, 64'(intf.out_hw), 64'(exp));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ref_y(input logic [N-1:0] x);
      return $countones(x) >= THR;
   endfunction

   // accept x, wait for the result, check latency/value, then transfer it
   task automatic run_vec(input string tag, input logic [N-1:0] x);
      int lat;
      intf.in_valid  = 1'b1;
      intf.in_x      = x;
      intf.out_ready = 1'b1;
      check({tag, "_in_ready"}, 64'(intf.in_ready), 64'd1);
      tick();
      intf.in_valid = 1'b0;
      intf.in_x     = ~x;
      lat = 0;
      while (!intf.out_valid && lat < 30) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd5);
      check({tag, "_y"}, 64'(intf.out_y), 64'(ref_y(x)));
      check_hw({tag, "_hw"}, $countones(x));
      tick();
      check({tag, "_valid_drop"}, 64'(intf.out_valid), 64'd0);
   endtask

   initial begin
      logic [N-1:0] x;
      logic [N-1:0] ones;
      logic [N-1:0] q[$];
      logic         acc_now, xfer, y_hold;
      int           acc_n, res_n, lat;

      ones = '1;
      intf.in_valid  = 1'b0;
      intf.in_x      = '0;
      intf.out_ready = 1'b0;
      #12;
      check("rst_in_ready", 64'(intf.in_ready), 64'd1);
      check("rst_out_valid", 64'(intf.out_valid), 64'd0);
      check("rst_out_y", 64'(intf.out_y), 64'd0);
      check_hw("rst_hw", 0);
      rst_n = 1'b1;
      tick();

      run_vec("zeros", '0);
      run_vec("ones18", 37'h0_0003_FFFF);
      run_vec("ones19", 37'h0_0007_FFFF);
      run_vec("upper19", 37'h1F_FFFC_0000);

      // all ones with backpressure; a second vector waits through DONE
      intf.in_valid = 1'b1;
      intf.in_x = ones;
      intf.out_ready = 1'b0;
      tick();
      intf.in_x = 37'h0_0000_000F;
      lat = 0;
      while (!intf.out_valid && lat < 30) begin
         tick();
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd5);
      y_hold = intf.out_y;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 64'(intf.out_valid), 64'd1);
         check("bp_y", 64'(intf.out_y), 64'd1);
         check_hw("bp_hw", N);
         check("bp_in_ready", 64'(intf.in_ready), 64'd0);
         tick();
      end
      check("bp_y_stable", 64'(intf.out_y), 64'(y_hold));
      intf.out_ready = 1'b1;
      tick();
      check("bp_xfer_valid", 64'(intf.out_valid), 64'd0);
      check("bp_xfer_in_ready", 64'(intf.in_ready), 64'd1);
      tick();
      intf.in_valid = 1'b0;
      check("bp_next_accepted", 64'(intf.in_ready), 64'd0);
      lat = 0;
      while (!intf.out_valid && lat < 30) begin
         tick();
         lat++;
      end
      check("bp_next_latency", 64'(lat), 64'd5);
      check("bp_next_y", 64'(intf.out_y), 64'd0);
      check_hw("bp_next_hw", 4);
      tick();

      // reset mid-accumulation discards the vector
      intf.in_valid = 1'b1;
      intf.in_x = ones;
      tick();
      intf.in_valid = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(intf.out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(intf.in_ready), 64'd1);
      #3;
      rst_n = 1'b1;
      repeat (8) begin
         tick();
         check("mid_rst_no_stale", 64'(intf.out_valid), 64'd0);
      end
      run_vec("post_rst", '0);

      // randomized traffic against the queue model
      acc_n = 0;
      res_n = 0;
      intf.in_valid = 1'b0;
      for (int cyc = 0; cyc < 80000 && res_n < NRAND; cyc++) begin
         if (!intf.in_valid && acc_n < NRAND && $urandom_range(3) != 0) begin
            x = N'({$urandom(), $urandom()});
            intf.in_valid = 1'b1;
            intf.in_x = x;
         end
         intf.out_ready = ($urandom_range(3) != 0);
         acc_now = intf.in_valid && intf.in_ready;
         xfer = intf.out_valid && intf.out_ready;
         if (xfer) begin
            if (q.size() == 0) begin
               check("rand_spurious", 64'd1, 64'd0);
            end else begin
               x = q.pop_front();
               check("rand_y", 64'(intf.out_y), 64'(ref_y(x)));
               check_hw("rand_hw", $countones(x));
            end
            res_n++;
         end
         if (acc_now) begin
            q.push_back(intf.in_x);
            acc_n++;
         end
         tick();
         if (acc_now) intf.in_valid = 1'b0;
      end
      check("rand_results", 64'(res_n), 64'(NRAND));
      check("rand_queue_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
